int_vector_ctrl: RTL and testbench

Interrupt controller sequencing the 16-way, 16-bit vector-select mux in the interrupt path. Latches edge events on 16 interrupt lines, masks them, picks the highest-priority pending source, and drives the mux select so the CPU fetches that source's handler vector. Runs a request/acknowledge/end-of-interrupt handshake with the control unit, one interrupt in service at a time.

---
 rtl/int_pkg.sv | 15 +
 rtl/prio_enc16.sv | 22 ++
 rtl/int_vector_ctrl.sv | 92 +++++++++
 tb/tb_int_vector_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared constants and FSM encoding for the interrupt vector controller.
// The source count is fixed by the width of the vector-select mux.
package int_pkg;

   localparam int NSRC = 16;
   localparam int SELW = 4;

   // 2'd3 is unused; the controller decodes it as IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

endpackage

// File: rtl/prio_enc16.sv
// 16->4 fixed-priority encoder: lowest set index wins, valid when any bit is set.
module prio_enc16
   import int_pkg::*;
(
   input  logic [NSRC-1:0] req,
   output logic [SELW-1:0] idx,
   output logic            valid
);

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment so that no path leaves it unassigned (no latch).
   always_comb begin
      idx = '0;
      // Scan downward so the last hit, i.e. the lowest index, is the one kept.
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) idx = SELW'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/int_vector_ctrl.sv
// Interrupt controller: edge-latches 16 lines, masks them, and sequences the
// vector-mux select through a request/acknowledge/end-of-interrupt handshake.
module int_vector_ctrl
   import int_pkg::*;
#(
   parameter int NSRC = int_pkg::NSRC,
   parameter int SELW = int_pkg::SELW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_in,
   output logic [NSRC-1:0] mask,
   output logic [NSRC-1:0] pending,
   output logic            int_req,
   input  logic            int_ack,
   input  logic            eoi,
   output logic [SELW-1:0] sel,
   output logic            active
);

   state_t          state;
   state_t          state_nx;
   logic [NSRC-1:0] irq_d;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] clr;
   logic [NSRC-1:0] eligible;
   logic [SELW-1:0] win_idx;
   logic            win_vld;

   assign rise     = irq & ~irq_d;
   assign eligible = pending & mask;

   prio_enc16 u_prio (
      .req   (eligible),
      .idx   (win_idx),
      .valid (win_vld)
   );

   always_comb begin
      clr = '0;
      if (state == ST_REQ && int_ack) clr[sel] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_d   <= '0;
         pending <= '0;
         mask    <= '0;
      end else begin
         irq_d   <= irq;
         // A new rise on the bit being acknowledged survives the clear.
         pending <= (pending & ~clr) | rise;
         if (mask_we) mask <= mask_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Select is captured once on grant and held through request and service.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              sel <= '0;
      else if (state == ST_IDLE && win_vld) sel <= win_idx;
   end

   always_comb begin
      state_nx = ST_IDLE;
      case (state)
         ST_IDLE: state_nx = win_vld ? ST_REQ  : ST_IDLE;
         ST_REQ:  state_nx = int_ack ? ST_SVC  : ST_REQ;
         ST_SVC:  state_nx = eoi     ? ST_IDLE : ST_SVC;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      int_req = 1'b0;
      active  = 1'b0;
      case (state)
         ST_REQ:  int_req = 1'b1;
         ST_SVC:  active  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_int_vector_ctrl.sv
// Self-checking bench for int_vector_ctrl: directed handshake scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_int_vector_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] irq;
   logic        mask_we;
   logic [15:0] mask_in;
   logic [15:0] mask;
   logic [15:0] pending;
   logic        int_req;
   logic        int_ack;
   logic        eoi;
   logic [3:0]  sel;
   logic        active;

   int_vector_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .irq     (irq),
      .mask_we (mask_we),
      .mask_in (mask_in),
      .mask    (mask),
      .pending (pending),
      .int_req (int_req),
      .int_ack (int_ack),
      .eoi     (eoi),
      .sel     (sel),
      .active  (active)
   );

   always #5 clk = ~clk;

   // Behavioural model: events latched as a bit set, one grant at a time.
   logic [15:0] m_pend;
   logic [15:0] m_mask;
   logic [15:0] m_prev;
   bit          m_req;
   bit          m_act;
   int          m_sel;

   int n_vec = 0;
   int n_bad = 0;
   int dut_svc [16];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int first_set(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_mask = '0;
      m_prev = '0;
      m_req  = 1'b0;
      m_act  = 1'b0;
      m_sel  = 0;
   endtask

   task automatic model_edge();
      logic [15:0] rise;
      logic [15:0] elig;
      rise = irq & ~m_prev;
      elig = m_pend & m_mask;
      if (!m_req && !m_act) begin
         if (elig != 0) begin
            m_sel = first_set(elig);
            m_req = 1'b1;
         end
      end else if (m_req) begin
         if (int_ack) begin
            m_pend[m_sel] = 1'b0;
            m_req = 1'b0;
            m_act = 1'b1;
         end
      end else if (eoi) begin
         m_act = 1'b0;
      end
      m_pend = m_pend | rise;
      if (mask_we) m_mask = mask_in;
      m_prev = irq;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".req"},  {15'b0, int_req}, {15'b0, m_req});
      check({tag, ".act"},  {15'b0, active},  {15'b0, m_act});
      check({tag, ".pend"}, pending,          m_pend);
      check({tag, ".mask"}, mask,             m_mask);
      if (m_req || m_act) check({tag, ".sel"}, {12'b0, sel}, 16'(m_sel));
   endtask

   task automatic tick(input string tag);
      if (int_req && int_ack) dut_svc[sel]++;
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic auto_ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         int_ack = m_req;
         eoi     = m_act;
         tick(tag);
      end
      int_ack = 1'b0;
      eoi     = 1'b0;
   endtask

   task automatic write_mask(input logic [15:0] v);
      mask_we = 1'b1;
      mask_in = v;
      tick("mask_wr");
      mask_we = 1'b0;
   endtask

   initial begin
      logic [15:0] flip;
      foreach (dut_svc[i]) dut_svc[i] = 0;
      rst = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0; int_ack = 1'b0; eoi = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      compare_all("reset");

      // Masked event stays pending, then arbitrates once enabled.
      irq = 16'h0020; tick("s1_rise");
      check("s1_pend", pending, 16'h0020);
      check("s1_noreq", {15'b0, int_req}, 16'h0000);
      irq = '0; tick("s1_idle");
      write_mask(16'hFFFF);
      tick("s1_grant");
      check("s1_req", {15'b0, int_req}, 16'h0001);
      check("s1_sel", {12'b0, sel}, 16'd5);
      int_ack = 1'b1; tick("s1_ack"); int_ack = 1'b0;
      eoi = 1'b1; tick("s1_eoi"); eoi = 1'b0;
      tick("s1_gap");

      // Simultaneous sources: lowest index first, then the other after EOI.
      irq = 16'h0208; tick("s2_rise");
      irq = '0; tick("s2_grant");
      check("s2_sel3", {12'b0, sel}, 16'd3);
      int_ack = 1'b1; tick("s2_ack"); int_ack = 1'b0;
      check("s2_pend", pending, 16'h0200);
      eoi = 1'b1; tick("s2_eoi"); eoi = 1'b0;
      tick("s2_next");
      check("s2_sel9", {12'b0, sel}, 16'd9);
      check("s2_req9", {15'b0, int_req}, 16'h0001);

      // Higher priority arrival during REQ does not re-arbitrate.
      irq = 16'h0002; tick("s3_rise");
      irq = '0; tick("s3_hold");
      check("s3_sel_held", {12'b0, sel}, 16'd9);
      int_ack = 1'b1; tick("s3_ack"); int_ack = 1'b0;
      eoi = 1'b1; tick("s3_eoi"); eoi = 1'b0;
      tick("s3_next");
      check("s3_sel1", {12'b0, sel}, 16'd1);
      auto_ticks(4, "s3_drain");

      // Held level yields one event; fall and re-rise yields another.
      irq = 16'h0080;
      for (int i = 0; i < 20; i++) begin
         int_ack = m_req; eoi = m_act;
         tick("s4_hold");
      end
      irq = '0;
      auto_ticks(6, "s4_drop");
      check("s4_once", 16'(dut_svc[7]), 16'd1);
      irq = 16'h0080;
      auto_ticks(5, "s4_rerise");
      irq = '0;
      auto_ticks(6, "s4_settle");
      check("s4_twice", 16'(dut_svc[7]), 16'd2);

      // Out-of-state handshakes are ignored; async reset aborts service.
      int_ack = 1'b1; tick("s5_ack_idle"); int_ack = 1'b0;
      irq = 16'h0050; tick("s5_rise");
      irq = '0; tick("s5_grant");
      eoi = 1'b1; tick("s5_eoi_req"); eoi = 1'b0;
      check("s5_still_req", {15'b0, int_req}, 16'h0001);
      int_ack = 1'b1; eoi = 1'b1; tick("s5_ack_eoi"); int_ack = 1'b0; eoi = 1'b0;
      check("s5_svc", {15'b0, active}, 16'h0001);
      #2 rst = 1'b1;
      #1;
      check("s5_rst_act",  {15'b0, active},  16'h0000);
      check("s5_rst_req",  {15'b0, int_req}, 16'h0000);
      check("s5_rst_pend", pending, 16'h0000);
      check("s5_rst_mask", mask, 16'h0000);
      model_reset();
      #1 rst = 1'b0;
      write_mask(16'hFFFF);

      // Rise coincides with acknowledge of the same source: it re-pends.
      irq = 16'h0004; tick("s6_rise");
      irq = '0; tick("s6_grant");
      irq = 16'h0004; int_ack = 1'b1; tick("s6_ack_rise");
      irq = '0; int_ack = 1'b0;
      check("s6_pend2", {15'b0, pending[2]}, 16'h0001);
      eoi = 1'b1; tick("s6_eoi"); eoi = 1'b0;
      tick("s6_again");
      check("s6_sel2", {12'b0, sel}, 16'd2);
      check("s6_req2", {15'b0, int_req}, 16'h0001);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         flip    = 16'($urandom & $urandom & $urandom);
         irq     = irq ^ flip;
         mask_we = ($urandom_range(0, 15) == 0);
         mask_in = 16'($urandom);
         int_ack = 1'($urandom_range(0, 1));
         eoi     = ($urandom_range(0, 2) == 0);
         tick("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
